// File: rtl/demux_deser_2ch_if.sv
// rtl/demux_deser_2ch_if.sv - demuxed bit lines in, deserialized words out
// DEMUX_DESER_ODD_PARITY_EN adds the parity_err signal to the bundle.
interface demux_deser_2ch_if #(
  parameter int WIDTH = 8
);
  logic             bit_valid;
  logic             sel;
  logic             y0;
  logic             y1;
  logic             flush;
  logic             err_clr;
  logic [WIDTH-1:0] word0;
  logic             word0_valid;
  logic [WIDTH-1:0] word1;
  logic             word1_valid;
  logic             route_err;
`ifdef DEMUX_DESER_ODD_PARITY_EN
  logic             parity_err;

  modport master (
    output bit_valid, sel, y0, y1, flush, err_clr,
    input  word0, word0_valid, word1, word1_valid, route_err, parity_err
  );
  modport slave (
    input  bit_valid, sel, y0, y1, flush, err_clr,
    output word0, word0_valid, word1, word1_valid, route_err, parity_err
  );
`else
  modport master (
    output bit_valid, sel, y0, y1, flush, err_clr,
    input  word0, word0_valid, word1, word1_valid, route_err
  );
  modport slave (
    input  bit_valid, sel, y0, y1, flush, err_clr,
    output word0, word0_valid, word1, word1_valid, route_err
  );
`endif
endinterface

// File: rtl/demux_deser_2ch.sv
// rtl/demux_deser_2ch.sv - two-channel LSB-first deserializer behind a 1:2 bit demux
// DEMUX_DESER_ODD_PARITY_EN: each word is followed by an odd-parity bit, checked on parity_err.
module demux_deser_2ch #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  demux_deser_2ch_if.slave bus
);

`ifdef DEMUX_DESER_ODD_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam int CW    = $clog2(WIDTH + 1) + 1;
`else
  localparam int FRAME = WIDTH;
  localparam int CW    = $clog2(WIDTH + 1);
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] shreg  [2];
  logic [WIDTH-1:0] shnext [2];
  logic [CW-1:0]    cnt    [2];
  logic [WIDTH-1:0] word   [2];
  logic [1:0]       wvalid;
  logic             route_err_q;
  logic             d;
  logic             other;
  logic [1:0]       take;
`ifdef DEMUX_DESER_ODD_PARITY_EN
  logic             parity_err_q;
`endif

  assign d     = bus.sel ? bus.y1 : bus.y0;
  assign other = bus.sel ? bus.y0 : bus.y1;
  assign take  = bus.bit_valid ? (bus.sel ? 2'b10 : 2'b01) : 2'b00;

  // Concatenate-then-shift keeps every shreg bit referenced; bit 0 simply falls off.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      shnext[c] = WIDTH'({d, shreg[c]} >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        shreg[c] <= '0;
        cnt[c]   <= '0;
        word[c]  <= '0;
      end
      wvalid      <= 2'b00;
      route_err_q <= 1'b0;
`ifdef DEMUX_DESER_ODD_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      wvalid <= 2'b00;
`ifdef DEMUX_DESER_ODD_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (bus.bit_valid && other) begin
        route_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        route_err_q <= 1'b0;
      end

      for (int c = 0; c < 2; c++) begin
        if (bus.flush) begin
          shreg[c] <= '0;
          cnt[c]   <= '0;
        end else if (take[c]) begin
          if (cnt[c] == LAST) begin
            cnt[c]    <= '0;
            wvalid[c] <= 1'b1;
`ifdef DEMUX_DESER_ODD_PARITY_EN
            // The incoming bit is the parity bit; data is already fully shifted in.
            word[c]      <= shreg[c];
            parity_err_q <= ~(^shreg[c] ^ d);
`else
            word[c]  <= shnext[c];
            shreg[c] <= shnext[c];
`endif
          end else begin
            cnt[c]   <= cnt[c] + CW'(1);
            shreg[c] <= shnext[c];
          end
        end
      end
    end
  end

  assign bus.word0       = word[0];
  assign bus.word1       = word[1];
  assign bus.word0_valid = wvalid[0];
  assign bus.word1_valid = wvalid[1];
  assign bus.route_err   = route_err_q;
`ifdef DEMUX_DESER_ODD_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_demux_deser_2ch.sv
// tb/tb_demux_deser_2ch.sv - self-checking bench for demux_deser_2ch (table, directed and random vs model)
module tb_demux_deser_2ch;
  localparam int W = 8;
`ifdef DEMUX_DESER_ODD_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  demux_deser_2ch_if #(.WIDTH(W)) bus ();
  demux_deser_2ch #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: bits are collected by arrival index into an accumulator per channel.
  logic [63:0]  m_acc  [2];
  int           m_n    [2];
  logic [W-1:0] m_word [2];
  bit           m_v    [2];
  bit           m_rerr;
`ifdef DEMUX_DESER_ODD_PARITY_EN
  bit           m_perr;
`endif

  task automatic m_step(input bit r, bv, s, a, b, f, cl);
    int c;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = '0; m_n[i] = 0; m_word[i] = '0; m_v[i] = 0;
      end
      m_rerr = 0;
`ifdef DEMUX_DESER_ODD_PARITY_EN
      m_perr = 0;
`endif
    end else begin
      m_v[0] = 0; m_v[1] = 0;
`ifdef DEMUX_DESER_ODD_PARITY_EN
      m_perr = 0;
`endif
      if (bv && (s ? a : b)) m_rerr = 1;
      else if (cl) m_rerr = 0;
      if (f) begin
        for (int i = 0; i < 2; i++) begin m_acc[i] = '0; m_n[i] = 0; end
      end else if (bv) begin
        c = s ? 1 : 0;
        m_acc[c][m_n[c]] = s ? b : a;
        m_n[c]++;
        if (m_n[c] == FRAME) begin
          m_word[c] = m_acc[c][W-1:0];
          m_v[c] = 1;
`ifdef DEMUX_DESER_ODD_PARITY_EN
          m_perr = ($countones(m_acc[c]) % 2) == 0;
`endif
          m_acc[c] = '0;
          m_n[c] = 0;
        end
      end
    end
  endtask

  task automatic apply(input bit r, bv, s, a, b, f, cl);
    rst = r; bus.bit_valid = bv; bus.sel = s; bus.y0 = a; bus.y1 = b;
    bus.flush = f; bus.err_clr = cl;
    m_step(r, bv, s, a, b, f, cl);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit ch, input bit v);
    apply(0, 1, ch, ch ? 1'b0 : v, ch ? v : 1'b0, 0, 0);
  endtask

  function automatic bit frame_bit(input logic [W-1:0] w, input int k);
    if (k < W) return w[k];
    return ~^w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".word0"}, 32'(bus.word0), 0);
    chk({nm, ".v0"}, 32'(bus.word0_valid), 0);
    chk({nm, ".word1"}, 32'(bus.word1), 0);
    chk({nm, ".v1"}, 32'(bus.word1_valid), 0);
    chk({nm, ".rerr"}, 32'(bus.route_err), 0);
`ifdef DEMUX_DESER_ODD_PARITY_EN
    chk({nm, ".perr"}, 32'(bus.parity_err), 0);
`endif
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".word0"}, 32'(bus.word0), 32'(m_word[0]));
    chk({nm, ".v0"}, 32'(bus.word0_valid), 32'(m_v[0]));
    chk({nm, ".word1"}, 32'(bus.word1), 32'(m_word[1]));
    chk({nm, ".v1"}, 32'(bus.word1_valid), 32'(m_v[1]));
    chk({nm, ".rerr"}, 32'(bus.route_err), 32'(m_rerr));
`ifdef DEMUX_DESER_ODD_PARITY_EN
    chk({nm, ".perr"}, 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  typedef struct {
    bit r, bv, s, a, b, f, cl;
    logic [W-1:0] w0; bit v0; logic [W-1:0] w1; bit v1; bit re;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0};
    tbl[4] = '{0, 1, 1, 1, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0};

    bus.bit_valid = 0; bus.sel = 0; bus.y0 = 0; bus.y1 = 0;
    bus.flush = 0; bus.err_clr = 0;

    apply(1, 0, 0, 0, 0, 0, 0); chk_zero("rst1");
    apply(1, 0, 0, 0, 0, 0, 0); chk_zero("rst2");
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0); chk_zero("idle");
    end

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].r, tbl[i].bv, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].cl);
      chk($sformatf("tbl%0d.word0", i), 32'(bus.word0), 32'(tbl[i].w0));
      chk($sformatf("tbl%0d.v0", i), 32'(bus.word0_valid), 32'(tbl[i].v0));
      chk($sformatf("tbl%0d.word1", i), 32'(bus.word1), 32'(tbl[i].w1));
      chk($sformatf("tbl%0d.v1", i), 32'(bus.word1_valid), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d.rerr", i), 32'(bus.route_err), 32'(tbl[i].re));
    end

    // Channel 0 word 8'h4D
    for (int k = 0; k < FRAME; k++) begin
      send_bit(0, frame_bit(8'h4D, k));
      chk("ch0.v0", 32'(bus.word0_valid), 32'(k == FRAME - 1));
      chk("ch0.v1", 32'(bus.word1_valid), 0);
      if (k == FRAME - 1) chk("ch0.word0", 32'(bus.word0), 32'h4D);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("ch0.v0_drop", 32'(bus.word0_valid), 0);
    chk("ch0.word0_hold", 32'(bus.word0), 32'h4D);

    // Interleaved A5 / 3C, valids on consecutive cycles
    for (int k = 0; k < FRAME; k++) begin
      send_bit(0, frame_bit(8'hA5, k));
      chk("ilv.v0", 32'(bus.word0_valid), 32'(k == FRAME - 1));
      chk("ilv.v1a", 32'(bus.word1_valid), 0);
      if (k == FRAME - 1) chk("ilv.word0", 32'(bus.word0), 32'hA5);
      send_bit(1, frame_bit(8'h3C, k));
      chk("ilv.v1", 32'(bus.word1_valid), 32'(k == FRAME - 1));
      chk("ilv.v0b", 32'(bus.word0_valid), 0);
      if (k == FRAME - 1) chk("ilv.word1", 32'(bus.word1), 32'h3C);
    end

    // Partial word on channel 1 discarded by flush
    send_bit(1, 0); send_bit(1, 1); send_bit(1, 0);
    apply(0, 1, 1, 0, 1, 1, 0);
    chk("flush.v1", 32'(bus.word1_valid), 0);
    chk("flush.word1_hold", 32'(bus.word1), 32'h3C);
    for (int k = 0; k < FRAME; k++) begin
      send_bit(1, frame_bit(8'hFF, k));
      chk("flush.v1_seq", 32'(bus.word1_valid), 32'(k == FRAME - 1));
      if (k == FRAME - 1) chk("flush.word1", 32'(bus.word1), 32'hFF);
    end

    // Reset mid-word
    for (int k = 0; k < 5; k++) send_bit(0, 1);
    apply(1, 0, 0, 0, 0, 0, 0);
    chk_zero("midrst");
    for (int k = 0; k < FRAME; k++) begin
      send_bit(0, frame_bit(8'h01, k));
      chk("midrst.v0", 32'(bus.word0_valid), 32'(k == FRAME - 1));
      if (k == FRAME - 1) chk("midrst.word0", 32'(bus.word0), 32'h01);
    end

`ifdef DEMUX_DESER_ODD_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < W; k++) send_bit(0, frame_bit(8'h07, k));
      send_bit(0, p[0]);
      chk("par.v0", 32'(bus.word0_valid), 1);
      chk("par.word0", 32'(bus.word0), 32'h07);
      chk("par.perr", 32'(bus.parity_err), 32'(p));
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("par.perr_drop", 32'(bus.parity_err), 0);
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit r, bv, s, dd, bad_line, f, cl;
      r        = ($urandom_range(63) == 0);
      bv       = ($urandom_range(3) != 0);
      s        = $urandom_range(1);
      dd       = $urandom_range(1);
      bad_line = ($urandom_range(15) == 0);
      f        = ($urandom_range(31) == 0);
      cl       = ($urandom_range(15) == 0);
      apply(r, bv, s, s ? bad_line : dd, s ? dd : bad_line, f, cl);
      chk_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_deser_2ch.md
Name: demux_deser_2ch

Overview:
- Downstream consumer of a 1:2 bit demultiplexer. Takes the two demuxed bit lines (y0, y1), the select that routed them, and a bit-valid strobe.
- Deserializes each channel independently, LSB-first, into WIDTH-bit words with a one-cycle valid pulse per word.
- Also checks the demux output invariant: the non-selected line must be 0.

Parameters:
- WIDTH, 8, word length in bits per channel; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bit_valid  input  1  a bit is present on the selected line this cycle
- sel  input  1  routing select fed to the upstream demux; 0 = channel 0, 1 = channel 1
- y0  input  1  demux output 0
- y1  input  1  demux output 1
- flush  input  1  discard partial words on both channels
- err_clr  input  1  clear sticky route_err
- word0  output  WIDTH  last completed channel-0 word
- word0_valid  output  1  one-cycle pulse, word0 updated
- word1  output  WIDTH  last completed channel-1 word
- word1_valid  output  1  one-cycle pulse, word1 updated
- route_err  output  1  sticky: non-selected line was 1 during bit_valid
- parity_err  output  1  present only with ODD_PARITY_EN; see Optional Feature

Behaviour:
- Reset (rst=1 at clk edge):
  - word0, word1, both shift registers and both bit counters go to 0.
  - word0_valid, word1_valid, route_err and parity_err go to 0.
  - Reset has priority over all other inputs. Reset mid-word discards the partial word.
- Bit acceptance:
  - Happens when bit_valid=1. Channel c = sel; data bit d = sel ? y1 : y0.
  - Channel c shift register takes shreg_c <= {d, shreg_c[WIDTH-1:1]}, so the first bit received lands in bit 0.
  - cnt_c increments. Each cnt_c is $clog2(WIDTH+1) bits wide (widened by one if ODD_PARITY_EN is defined).
  - The other channel's register and counter hold.
- Word completion:
  - Occurs when the accepted bit makes cnt_c reach WIDTH.
  - Next edge: word_c <= {d, shreg_c[WIDTH-1:1]}, word_c_valid=1 for exactly one cycle, cnt_c <= 0.
  - Latency: valid is asserted in the cycle after the edge that samples the last bit.
  - word_c holds its value until the next completion.
- Back-to-back words on one channel are allowed, with no dead cycle. Alternating channels bit-by-bit is allowed; the counters are independent.
- bit_valid=0: no state change except valid pulses deasserting.
- route_err:
  - Set when bit_valid=1 and the non-selected line (sel ? y0 : y1) is 1. That bit is still accepted.
  - Sticky until err_clr or rst. Set has priority over err_clr in the same cycle.
- flush:
  - Zeroes both counters and both shift registers at the next edge.
  - A bit arriving in the same cycle as flush is dropped.
  - flush does not alter word0/word1 or route_err.
  - A completion coinciding with flush is suppressed (no valid pulse).
- Both valid pulses can never occur in the same cycle, because only one bit is accepted per cycle.

Optional Feature:
- Macro: DEMUX_DESER_ODD_PARITY_EN.
- Defined:
  - Each word is followed by one parity bit on the same channel, so a frame is WIDTH+1 bits.
  - On the parity bit, the word completes as above.
  - parity_err is a one-cycle pulse aligned with word_c_valid. It is 1 when the XOR of the WIDTH data bits and the parity bit is 0, i.e. odd parity is violated.
  - The parity bit is not stored in word_c.
- Undefined: the parity_err port is absent, frames are WIDTH bits, and there is no parity logic.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles, then bit_valid=0 for 10 cycles.
  - Required: all outputs 0 throughout.
- Channel 0 word (WIDTH=8):
  - Stimulus: sel=0, 8 consecutive bit_valid with y0 = 1,0,1,1,0,0,1,0 (first to last), y1=0.
  - Required: word0=8'h4D with a one-cycle word0_valid; word1_valid never asserts.
- Interleaved channels:
  - Stimulus: alternate sel 0/1 each cycle for 16 bits. Channel 0 sends 8'hA5 LSB-first, channel 1 sends 8'h3C.
  - Required: word0_valid then word1_valid on consecutive cycles, with word0=8'hA5 and word1=8'h3C.
- Route error and flush:
  - Stimulus: sel=0 with y0=1, y1=1 on one bit.
  - Required: route_err=1 and stays set; err_clr clears it.
  - Stimulus: 3 bits into channel 1, then flush, then 8 bits of 8'hFF.
  - Required: word1=8'hFF after exactly 8 post-flush bits.
- Reset mid-word:
  - Stimulus: 5 bits into channel 0, rst for one cycle, then 8 bits of 8'h01.
  - Required: word0=8'h01, with the valid pulse after the 8th post-reset bit.
- Parity (macro defined):
  - Stimulus: channel 0 sends 8'h07 plus parity bit 0.
  - Required: word0_valid=1 with parity_err=0.
  - Stimulus: the same frame with parity bit 1.
  - Required: parity_err=1 for one cycle, with word0=8'h07.
